// File: rtl/rob_mc.sv
// Multi-channel reorder buffer: one dispatch per cycle, WB_PORTS writeback channels,
// in-order retire of up to COMMIT_WIDTH entries, bypassing operand lookup, redirect flush.
module rob_mc #(
    parameter int DEPTH_BIT    = 4,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              alloc_valid,
    input  logic                              alloc_ready,
    input  logic [1:0]                        alloc_type,
    input  logic [4:0]                        alloc_rd,
    input  logic [31:0]                       alloc_val,
    input  logic [31:0]                       alloc_pc,
    output logic [DEPTH_BIT-1:0]              alloc_id,
    output logic                              rob_full,
    output logic [DEPTH_BIT:0]                rob_count,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*DEPTH_BIT-1:0]     wb_id,
    input  logic [WB_PORTS*32-1:0]            wb_val,
    input  logic [WB_PORTS-1:0]               wb_redirect,
    output logic [COMMIT_WIDTH-1:0]           commit_valid,
    output logic [COMMIT_WIDTH*2-1:0]         commit_type,
    output logic [COMMIT_WIDTH*5-1:0]         commit_rd,
    output logic [COMMIT_WIDTH*32-1:0]        commit_val,
    output logic [COMMIT_WIDTH*DEPTH_BIT-1:0] commit_id,
    output logic                              head_mem,
    input  logic [DEPTH_BIT-1:0]              q1_id,
    input  logic [DEPTH_BIT-1:0]              q2_id,
    output logic                              q1_ready,
    output logic                              q2_ready,
    output logic [31:0]                       q1_val,
    output logic [31:0]                       q2_val,
    output logic                              flush_out,
    output logic [31:0]                       pc_fact
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [1:0] TYPE_RD = 2'd0;
    localparam logic [1:0] TYPE_LD = 2'd1;
    localparam logic [1:0] TYPE_ST = 2'd2;
    localparam logic [1:0] TYPE_BR = 2'd3;
    localparam logic [DEPTH_BIT:0] ONE = (DEPTH_BIT+1)'(1);

    logic                 busy_q  [DEPTH];
    logic                 busy_d  [DEPTH];
    logic                 ready_q [DEPTH];
    logic                 ready_d [DEPTH];
    logic                 redir_q [DEPTH];
    logic                 redir_d [DEPTH];
    logic [1:0]           type_q  [DEPTH];
    logic [1:0]           type_d  [DEPTH];
    logic [4:0]           rd_q    [DEPTH];
    logic [4:0]           rd_d    [DEPTH];
    logic [31:0]          val_q   [DEPTH];
    logic [31:0]          val_d   [DEPTH];
    logic [31:0]          pc_q    [DEPTH];
    logic [31:0]          pc_d    [DEPTH];
    logic [DEPTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 flush_q, flush_d;
    logic [31:0]          pc_fact_q, pc_fact_d;

    logic                    alloc_fire;
    logic [COMMIT_WIDTH-1:0] cv;
    logic [DEPTH_BIT:0]      n_commit;
    logic                    flush_now;
    logic [31:0]             flush_pc;
    logic                    chain, mem_seen;
    logic [DEPTH_BIT-1:0]    cidx, sidx, widx;

    function automatic logic is_mem(input logic [1:0] t);
        return (t == TYPE_LD) || (t == TYPE_ST);
    endfunction

    // Lowest priority is evaluated first so later hits overwrite it.
    function automatic logic [32:0] lookup(input logic [DEPTH_BIT-1:0] id);
        logic [32:0] r;
        r = 33'd0;
        if (alloc_fire && alloc_ready && (tail_q == id)) r = {1'b1, alloc_val};
        else r = r;
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_id[k*DEPTH_BIT +: DEPTH_BIT] == id)) r = {1'b1, wb_val[k*32 +: 32]};
            else r = r;
        end
        if (busy_q[id] && ready_q[id]) r = {1'b1, val_q[id]};
        else r = r;
        return r;
    endfunction

    assign rob_full     = (count_q == (DEPTH_BIT+1)'(DEPTH));
    assign rob_count    = count_q;
    assign alloc_id     = tail_q;
    assign alloc_fire   = rdy_in && alloc_valid && !rob_full && !flush_q;
    assign flush_out    = flush_q;
    assign pc_fact      = pc_fact_q;
    assign head_mem     = busy_q[head_q] && is_mem(type_q[head_q]);
    assign commit_valid = cv;

    // Commit slot selection and retire outputs from the head entries.
    always_comb begin
        chain       = rdy_in;
        mem_seen    = 1'b0;
        flush_now   = 1'b0;
        flush_pc    = 32'd0;
        n_commit    = '0;
        cv          = '0;
        cidx        = head_q;
        commit_type = '0;
        commit_rd   = '0;
        commit_val  = '0;
        commit_id   = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            cidx = head_q + DEPTH_BIT'(s);
            commit_id[s*DEPTH_BIT +: DEPTH_BIT] = cidx;
            if (chain && busy_q[cidx] && ready_q[cidx] && !(mem_seen && is_mem(type_q[cidx]))) begin
                cv[s]                 = 1'b1;
                n_commit              = n_commit + ONE;
                commit_type[s*2 +: 2] = type_q[cidx];
                if ((type_q[cidx] == TYPE_RD) || (type_q[cidx] == TYPE_LD)) begin
                    commit_rd[s*5 +: 5]   = rd_q[cidx];
                    commit_val[s*32 +: 32] = val_q[cidx];
                end else begin
                    commit_rd[s*5 +: 5]   = 5'd0;
                    commit_val[s*32 +: 32] = 32'd0;
                end
                mem_seen = mem_seen || is_mem(type_q[cidx]);
                // Nothing younger than a redirecting branch may retire.
                if ((type_q[cidx] == TYPE_BR) && redir_q[cidx]) begin
                    flush_now = 1'b1;
                    flush_pc  = val_q[cidx];
                    chain     = 1'b0;
                end else begin
                    chain = 1'b1;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Operand lookup with same-cycle bypass.
    always_comb begin
        {q1_ready, q1_val} = lookup(q1_id);
        {q2_ready, q2_val} = lookup(q2_id);
    end

    // Next-state: writeback, retire, flush, allocate.
    always_comb begin
        busy_d    = busy_q;
        ready_d   = ready_q;
        redir_d   = redir_q;
        type_d    = type_q;
        rd_d      = rd_q;
        val_d     = val_q;
        pc_d      = pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        flush_d   = flush_q;
        pc_fact_d = pc_fact_q;
        sidx      = head_q;
        widx      = '0;
        if (rdy_in) begin
            flush_d = 1'b0;
            for (int k = WB_PORTS - 1; k >= 0; k--) begin
                widx = wb_id[k*DEPTH_BIT +: DEPTH_BIT];
                if (wb_valid[k] && busy_q[widx]) begin
                    ready_d[widx] = 1'b1;
                    val_d[widx]   = wb_val[k*32 +: 32];
                    redir_d[widx] = wb_redirect[k] && (type_q[widx] == TYPE_BR);
                end else begin
                    widx = widx;
                end
            end
            for (int s = 0; s < COMMIT_WIDTH; s++) begin
                sidx = head_q + DEPTH_BIT'(s);
                if (cv[s]) begin
                    busy_d[sidx]  = 1'b0;
                    ready_d[sidx] = 1'b0;
                    redir_d[sidx] = 1'b0;
                end else begin
                    sidx = sidx;
                end
            end
            if (flush_now) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                    redir_d[i] = 1'b0;
                end
                head_d    = '0;
                tail_d    = '0;
                count_d   = '0;
                flush_d   = 1'b1;
                pc_fact_d = flush_pc;
            end else begin
                head_d = head_q + n_commit[DEPTH_BIT-1:0];
                if (alloc_fire) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = alloc_ready;
                    redir_d[tail_q] = 1'b0;
                    type_d[tail_q]  = alloc_type;
                    rd_d[tail_q]    = alloc_rd;
                    val_d[tail_q]   = alloc_ready ? alloc_val : 32'd0;
                    pc_d[tail_q]    = alloc_pc;
                    tail_d          = tail_q + DEPTH_BIT'(1);
                end else begin
                    tail_d = tail_q;
                end
                count_d = count_q + {{DEPTH_BIT{1'b0}}, alloc_fire} - n_commit;
            end
        end else begin
            flush_d = flush_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                redir_q[i] <= 1'b0;
                type_q[i]  <= 2'd0;
                rd_q[i]    <= 5'd0;
                val_q[i]   <= 32'd0;
                pc_q[i]    <= 32'd0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            flush_q   <= 1'b0;
            pc_fact_q <= 32'd0;
        end else begin
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            redir_q   <= redir_d;
            type_q    <= type_d;
            rd_q      <= rd_d;
            val_q     <= val_d;
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            pc_fact_q <= pc_fact_d;
        end
    end
endmodule
